// File: rtl/param_memory_pkg.sv
// Shared types and helpers for param_memory: FSM state encoding, legal
// read-latency bounds and the even-parity helper.
package param_memory_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;
    localparam int PAR_MAX_W    = 64;

    // Callers zero-extend to PAR_MAX_W; the padding does not change the XOR.
    function automatic logic par_even(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return register chain of DEPTH stages carrying {valid, data}.
// Data stages only load on a valid beat so the output holds between reads.
module mem_rd_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic         r_valid;
            logic [W-1:0] r_data;
            logic         w_vin;
            logic [W-1:0] w_din;

            if (gi == 0) begin : g_first
                assign w_vin = i_valid;
                assign w_din = i_data;
            end else begin : g_next
                assign w_vin = g_stage[gi-1].r_valid;
                assign w_din = g_stage[gi-1].r_data;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= w_vin;
                    if (w_vin) begin
                        r_data <= w_din;
                    end
                end
            end
        end
    endgenerate

    assign o_valid = g_stage[DEPTH-1].r_valid;
    assign o_data  = g_stage[DEPTH-1].r_data;

endmodule

// File: rtl/param_memory.sv
// Parametrised single-port RAM with post-reset / on-request clear sweep,
// read-valid qualification and access-error reporting. Optional stored
// parity is enabled with the PARAM_MEMORY_PARITY_EN macro.
module param_memory
    import param_memory_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              ready,
    output logic              access_err
`ifdef PARAM_MEMORY_PARITY_EN
    ,
    input  logic              inj_parity_flip,
    output logic              rd_parity_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
`ifdef PARAM_MEMORY_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    generate
        if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
            $error("param_memory: READ_LAT must be 1 or 2");
        end
    endgenerate

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_ready;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [WORD_W-1:0] w_wdata;
    logic [WORD_W-1:0] w_wr_word;
    logic              w_rd_en;
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rd_word;
    logic              r_rd_vld;
    logic              r_access_err;
    logic [WORD_W-1:0] w_pipe_in;
    logic [WORD_W-1:0] w_pipe_out;

    assign w_ready = (r_state == READY);
    assign w_rd_en = read & w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            CLEAR: begin
                if (r_cnt == CNT_W'(DEPTH - 1)) begin
                    w_state_next = READY;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            READY: begin
                if (clear_req) begin
                    w_state_next = CLEAR;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = CLEAR;
                w_cnt_next   = '0;
            end
        endcase
    end

`ifdef PARAM_MEMORY_PARITY_EN
    assign w_wr_word = {par_even(PAR_MAX_W'(data_in)) ^ inj_parity_flip, data_in};
`else
    assign w_wr_word = data_in;
`endif

    // The sweep owns the single write port while not ready.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = address;
        w_wdata = w_wr_word;
        if (!w_ready) begin
            w_we    = 1'b1;
            w_waddr = r_cnt[ADDR_W-1:0];
            w_wdata = '0;
        end else if (write) begin
            w_we = 1'b1;
        end
    end

    // Array and its read register stay unreset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        if (w_rd_en) begin
            r_rd_word <= r_mem[address];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_vld     <= 1'b0;
            r_access_err <= 1'b0;
        end else begin
            r_rd_vld     <= w_rd_en;
            r_access_err <= (write | read) & ~w_ready;
        end
    end

`ifdef PARAM_MEMORY_PARITY_EN
    assign w_pipe_in = {par_even(PAR_MAX_W'(r_rd_word[DATA_W-1:0])) ^ r_rd_word[DATA_W],
                        r_rd_word[DATA_W-1:0]};
`else
    assign w_pipe_in = r_rd_word;
`endif

    mem_rd_pipe #(
        .W     (WORD_W),
        .DEPTH (READ_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_rd_vld),
        .i_data  (w_pipe_in),
        .o_valid (rd_valid),
        .o_data  (w_pipe_out)
    );

    assign data_out   = w_pipe_out[DATA_W-1:0];
    assign ready      = w_ready;
    assign access_err = r_access_err;
`ifdef PARAM_MEMORY_PARITY_EN
    assign rd_parity_err = rd_valid & w_pipe_out[DATA_W];
`endif

endmodule

// File: tb/tb_param_memory.sv
// Self-checking bench for param_memory: table-driven read/write vectors plus
// hand-written clear, access-error and reset sequences, scored via a queue.
module tb_param_memory;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int READ_LAT = 1;
    localparam int DEPTH    = 2 ** ADDR_W;

    logic              clk;
    logic              rst;
    logic              clear_req;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              ready;
    logic              access_err;
`ifdef PARAM_MEMORY_PARITY_EN
    logic              inj_parity_flip;
    logic              rd_parity_err;
`endif

    param_memory #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .write      (write),
        .read       (read),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .ready      (ready),
        .access_err (access_err)
`ifdef PARAM_MEMORY_PARITY_EN
        ,
        .inj_parity_flip (inj_parity_flip),
        .rd_parity_err   (rd_parity_err)
`endif
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
        logic              perr;
    } sb_t;

    typedef struct {
        logic              wr;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] exp;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[9];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read-return monitor: pops one expectation per rd_valid pulse.
    always @(negedge clk) begin
        sb_t e;
        if (!rst) begin
            if (rd_valid) begin
                if (sbq.size() == 0) begin
                    check("rd_valid_unexpected", 64'(rd_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("rd_data", 64'(data_out), 64'(e.data));
                    check("rd_latency", 64'(cyc), 64'(e.due));
`ifdef PARAM_MEMORY_PARITY_EN
                    check("rd_parity_err", 64'(rd_parity_err), 64'(e.perr));
`endif
                end
            end
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                check("rd_missing", 64'(cyc), 64'(sbq[0].due));
                void'(sbq.pop_front());
            end
        end
    end

    // One clock of stimulus; a read expected to return pushes its result.
    task automatic access(input logic w, input logic r, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic cl, input logic exp_ok,
                          input logic [DATA_W-1:0] exp_d, input logic exp_pe);
        sb_t e;
        write     = w;
        read      = r;
        address   = a;
        data_in   = d;
        clear_req = cl;
        @(posedge clk);
        #1;
        if (r && exp_ok) begin
            e.data = exp_d;
            e.due  = cyc + READ_LAT;
            e.perr = exp_pe;
            sbq.push_back(e);
        end
        write     = 1'b0;
        read      = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            access(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic wait_ready(input int start, output int k);
        k = start;
        while (!ready && k < 64) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic read_all_const(input logic [DATA_W-1:0] v);
        for (int a = 0; a < DEPTH; a++) begin
            access(1'b0, 1'b1, ADDR_W'(a), '0, 1'b0, 1'b1, v, 1'b0);
        end
    endtask

    initial begin
        int k;
        rst       = 1'b1;
        clear_req = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        address   = '0;
        data_in   = '0;
`ifdef PARAM_MEMORY_PARITY_EN
        inj_parity_flip = 1'b0;
`endif

        vecs[0] = '{1'b1, 1'b0, 4'd1, 8'h02, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 4'd1, 8'h00, 8'h02};
        vecs[2] = '{1'b1, 1'b0, 4'd5, 8'hAA, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 4'd5, 8'h55, 8'hAA};
        vecs[4] = '{1'b0, 1'b1, 4'd5, 8'h00, 8'h55};
        vecs[5] = '{1'b1, 1'b0, 4'd7, 8'h3C, 8'h00};
        vecs[6] = '{1'b0, 1'b1, 4'd7, 8'h00, 8'h3C};
        vecs[7] = '{1'b1, 1'b0, 4'd0, 8'hFF, 8'h00};
        vecs[8] = '{1'b0, 1'b1, 4'd0, 8'h00, 8'hFF};

        // Reset values and sweep duration.
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_access_err", 64'(access_err), 64'd0);
        rst = 1'b0;
        wait_ready(0, k);
        check("init_sweep_cycles", 64'(k), 64'd16);
        read_all_const(8'h00);
        idle(3);

        // Table vectors, including read-before-write on the same address.
        for (int i = 0; i < 9; i++) begin
            access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din, 1'b0,
                   1'b1, vecs[i].exp, 1'b0);
        end
        access(1'b1, 1'b1, 4'd1, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0);
        access(1'b0, 1'b1, 4'd1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        idle(3);

        // clear_req with a same-cycle read; accesses during the sweep.
        access(1'b1, 1'b0, 4'd1, 8'h02, 1'b0, 1'b0, '0, 1'b0);
        access(1'b0, 1'b1, 4'd1, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0);
        check("clear_ready_drop", 64'(ready), 64'd0);
        access(1'b1, 1'b0, 4'd3, 8'h77, 1'b0, 1'b0, '0, 1'b0);
        check("err_on_write", 64'(access_err), 64'd1);
        idle(1);
        check("err_pulse_end", 64'(access_err), 64'd0);
        access(1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 1'b0, '0, 1'b0);
        check("err_on_read", 64'(access_err), 64'd1);
        access(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, '0, 1'b0);
        check("err_pulse_end2", 64'(access_err), 64'd0);
        wait_ready(4, k);
        check("clear_sweep_cycles", 64'(k), 64'd16);
        read_all_const(8'h00);
        idle(3);

        // Fill with address^FF, read back, clear, expect zeros.
        for (int a = 0; a < DEPTH; a++) begin
            access(1'b1, 1'b0, ADDR_W'(a), DATA_W'(a) ^ 8'hFF, 1'b0, 1'b0, '0, 1'b0);
        end
        for (int a = 0; a < DEPTH; a++) begin
            access(1'b0, 1'b1, ADDR_W'(a), '0, 1'b0, 1'b1, DATA_W'(a) ^ 8'hFF, 1'b0);
        end
        idle(3);
        access(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, '0, 1'b0);
        check("fill_clear_ready_drop", 64'(ready), 64'd0);
        wait_ready(0, k);
        check("fill_clear_cycles", 64'(k), 64'd16);
        read_all_const(8'h00);
        idle(3);

        // Reset with a read in flight.
        access(1'b1, 1'b0, 4'd4, 8'h44, 1'b0, 1'b0, '0, 1'b0);
        access(1'b0, 1'b1, 4'd4, 8'h00, 1'b0, 1'b1, 8'h44, 1'b0);
        idle(3);
        access(1'b0, 1'b1, 4'd4, 8'h00, 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_rd_valid", 64'(rd_valid), 64'd0);
        check("midrst_data_out", 64'(data_out), 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready(0, k);
        check("midrst_sweep_cycles", 64'(k), 64'd16);
        access(1'b0, 1'b1, 4'd4, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        idle(3);

`ifdef PARAM_MEMORY_PARITY_EN
        inj_parity_flip = 1'b1;
        access(1'b1, 1'b0, 4'd2, 8'h0F, 1'b0, 1'b0, '0, 1'b0);
        inj_parity_flip = 1'b0;
        access(1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 1'b1, 8'h0F, 1'b1);
        access(1'b1, 1'b0, 4'd2, 8'h0F, 1'b0, 1'b0, '0, 1'b0);
        access(1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 1'b1, 8'h0F, 1'b0);
        idle(3);
`endif

        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
